// File: rtl/tm_feedback_gen_if.sv
// Request and feedback bundle between a clause trainer and the feedback sweep block.
// include_bits carries the clause's include_or_not bits; "include" is a reserved word.
interface tm_feedback_gen_if #(
    parameter int N_LIT = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_type;
    logic             clause_out;
    logic [N_LIT-1:0] literals;
    logic [N_LIT-1:0] include_bits;
    logic [N_LIT-1:0] positive_feedback;
    logic [N_LIT-1:0] negative_feedback;
    logic             busy;
    logic             done;

    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
    // req_valid seen while req_ready is low is dropped, never queued.
    modport master (
        output req_valid, req_type, clause_out, literals, include_bits,
        input  req_ready, positive_feedback, negative_feedback, busy, done
    );
    modport slave (
        input  req_valid, req_type, clause_out, literals, include_bits,
        output req_ready, positive_feedback, negative_feedback, busy, done
    );
endinterface

// File: rtl/tm_feedback_gen.sv
// Tsetlin-machine feedback generator: sweeps one literal per cycle and issues
// Type I / Type II reward or penalty to that literal's automaton.
module tm_feedback_gen #(
    parameter int          N_LIT     = 8,
    parameter logic [15:0] S_THRESH  = 16'd6554,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    tm_feedback_gen_if.slave  bus,
    output logic [1:0]        o_dbg_state
);
    localparam int IDX_W = (N_LIT > 1) ? $clog2(N_LIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_type;
    logic             r_clause;
    logic [N_LIT-1:0] r_lits;
    logic [N_LIT-1:0] r_incl;
    logic [15:0]      r_lfsr;

    logic             w_accept;
    logic             w_hit;
    logic             w_lit;
    logic             w_inc;
    logic             w_pos;
    logic             w_neg;
    logic             w_lfsr_fb;
    logic [N_LIT-1:0] w_onehot;

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    assign w_hit     = (r_lfsr <= S_THRESH);
    assign w_lit     = r_lits[r_idx];
    assign w_inc     = r_incl[r_idx];
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_onehot  = {{(N_LIT-1){1'b0}}, 1'b1} << r_idx;

    // Type I with a firing clause and a true literal rewards on a miss; every other
    // Type I case shares the "included -> penalty, excluded -> reward on hit" rule.
    always_comb begin
        w_pos = 1'b0;
        w_neg = 1'b0;
        if (!r_type) begin
            if (r_clause && w_lit) begin
                if (!w_hit) begin
                    w_pos = w_inc;
                    w_neg = !w_inc;
                end
            end else if (w_hit) begin
                w_pos = !w_inc;
                w_neg = w_inc;
            end
        end else if (r_clause && !w_lit && !w_inc) begin
            w_neg = 1'b1;
        end
    end

    assign bus.positive_feedback = (r_state == S_SWEEP && w_pos) ? w_onehot : '0;
    assign bus.negative_feedback = (r_state == S_SWEEP && w_neg) ? w_onehot : '0;
    assign bus.req_ready         = (r_state == S_IDLE);
    assign bus.busy              = (r_state == S_SWEEP);
    assign bus.done              = (r_state == S_DONE);
    assign o_dbg_state           = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_type   <= 1'b0;
            r_clause <= 1'b0;
            r_lits   <= '0;
            r_incl   <= '0;
            r_lfsr   <= LFSR_SEED;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_type   <= bus.req_type;
                        r_clause <= bus.clause_out;
                        r_lits   <= bus.literals;
                        r_incl   <= bus.include_bits;
                        r_idx    <= '0;
                        r_state  <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    // The random stream moves only while literals consume it.
                    r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
                    if (r_idx == IDX_W'(N_LIT - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/tm_feedback_gen.md
TM_FEEDBACK_GEN -- requirements
Module: tm_feedback_gen

Interface
REQ-001 Parameter N_LIT, default 8, number of literals/automata served (power of 2, 2..64).
REQ-002 Parameter S_THRESH, default 16'd6554, threshold for the 1/s random event; hit probability = S_THRESH/65535.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  training request present.
REQ-007 req_ready  output  1  block idle; request accepted when req_valid && req_ready at a clock edge.
REQ-008 req_type  input  1  0 = Type I feedback, 1 = Type II feedback.
REQ-009 clause_out  input  1  current output of the clause being trained.
REQ-010 literals  input  N_LIT  literal values for the training sample.
REQ-011 include  input  N_LIT  include_or_not bits from the clause's automata.
REQ-012 positive_feedback  output  N_LIT  one-hot or zero; reward, reinforce the automaton's current action.
REQ-013 negative_feedback  output  N_LIT  one-hot or zero; penalty, push the automaton toward the opposite action.
REQ-014 busy  output  1  sweep in progress.
REQ-015 done  output  1  single-cycle pulse after the last literal.

Function
REQ-016 FSM states: IDLE, SWEEP, DONE; IDLE -> SWEEP on accept; SWEEP -> DONE when idx == N_LIT-1; DONE -> IDLE unconditionally.
REQ-017 On accept, req_type, clause_out, literals and include are captured and idx is cleared to 0; later input changes have no effect on the sweep.
REQ-018 In SWEEP, literal idx receives feedback in that cycle, combinationally decoded from the captured registers and the current LFSR value; idx increments by 1 per cycle.
REQ-019 Latency: accept at edge T; literal k feedback is visible in the cycle after edge T+k; done is high in the cycle after edge T+N_LIT; req_ready is high again after edge T+N_LIT+1.
REQ-020 Outputs: req_ready=1 only in IDLE; busy=1 only in SWEEP; done=1 only in DONE; both feedback vectors are zero outside SWEEP.
REQ-021 At most one bit, bit idx, of positive_feedback | negative_feedback is set per cycle; positive and negative are never both set.
REQ-022 hit = (lfsr <= S_THRESH); LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances only in SWEEP cycles.
REQ-023 Type I, clause_out=1, literal=1: included -> positive if !hit; excluded -> negative if !hit.
REQ-024 Type I, clause_out=1, literal=0: included -> negative if hit; excluded -> positive if hit.
REQ-025 Type I, clause_out=0, any literal: included -> negative if hit; excluded -> positive if hit.
REQ-026 Type II: clause_out=1, literal=0, excluded -> negative unconditionally; all other cases -> no feedback.
REQ-027 req_valid in SWEEP or DONE is ignored, and the request is not queued.
REQ-028 req_valid held high gives back-to-back sweeps separated only by the DONE and IDLE cycles.

Reset
REQ-029 When rst=1 at an edge: FSM -> IDLE, idx=0, captured registers=0, lfsr=LFSR_SEED; next cycle req_ready=1, busy=0, done=0, feedback vectors=0.
REQ-030 Reset mid-SWEEP aborts the sweep: no further feedback and no done pulse; rst takes priority over a simultaneous req_valid.

Verification (N_LIT=4)
REQ-031 S_THRESH=0, Type I, clause=1, literals=4'b0011, include=4'b0101 -> per cycle pos/neg = 0001/0000, 0000/0010, 0000/0000, 0000/0000; done next cycle.
REQ-032 Type II, clause=1, literals=4'b0101, include=4'b0010 -> neg=1000 at idx3 only; pos always 0000.
REQ-033 S_THRESH=16'hFFFF, Type I, clause=0, include=4'b1100 -> pos 0001, 0010 at idx0,1; neg 0100, 1000 at idx2,3.
REQ-034 req_valid pulsed during SWEEP -> req_ready=0, sweep unaffected, no second sweep.
REQ-035 rst asserted with idx=2 -> next cycle feedback=0, busy=0, req_ready=1, no done; the following sweep repeats the identical LFSR sequence.
REQ-036 Random check: S_THRESH=6554, 10000 sweeps of Type I clause=0 -> hit rate within 10% +/- 1%; the LFSR never reaches 0.
